// File: rtl/lottery_pkg.sv
// rtl/lottery_pkg.sv - shared types and constants for the lottery draw generator
package lottery_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_GAP,
        ST_FIN,
        ST_DONE
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 as a tap mask over bits [15:0]
    localparam logic [15:0] LFSR_POLY_TAPS = 16'hB400;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

endpackage

// File: rtl/lottery_lfsr16.sv
// rtl/lottery_lfsr16.sv - free-running 16-bit Fibonacci LFSR, seed load on reset
module lottery_lfsr16
    import lottery_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    output digit_t       nibble
);

    // an all-zero state would lock the register, so a zero seed loads 1 instead
    localparam logic [15:0] LOAD = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= {state[14:0], ^(state & LFSR_POLY_TAPS)};
        end
    end

    assign nibble = state[3:0];

endmodule

// File: rtl/lottery_draw.sv
// rtl/lottery_draw.sv - draws DIGITS random decimal digits and sends them over num/insert/finish
// Optional: LOTTERY_DRAW_UNIQUE_EN rejects digits already drawn in the current round.
module lottery_draw
    import lottery_pkg::*;
#(
    parameter int          DIGITS     = 5,
    parameter int          GAP_CYCLES = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [3:0]            num,
    output logic                  insert,
    output logic                  finish,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   drawn
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(GAP_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] gap_cnt;
    digit_t           cand;
    logic             accept;

    lottery_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .nibble (cand)
    );

`ifdef LOTTERY_DRAW_UNIQUE_EN
    logic dup;

    // only slots below index hold this round's digits; higher slots are still 0
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) < index) && (drawn[4*i +: 4] == cand)) begin
                dup = 1'b1;
            end
        end
    end

    assign accept = (cand <= DIGIT_MAX) && !dup;
`else
    assign accept = (cand <= DIGIT_MAX);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            index   <= '0;
            gap_cnt <= '0;
            num     <= 4'd0;
            insert  <= 1'b0;
            finish  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            drawn   <= '0;
        end else begin
            insert <= 1'b0;
            finish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_GEN;
                        index <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_GEN: begin
                    if (accept) begin
                        num     <= cand;
                        insert  <= 1'b1;
                        gap_cnt <= CNT_W'(GAP_CYCLES);
                        state   <= ST_GAP;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (IDX_W'(i) == index) begin
                                drawn[4*i +: 4] <= cand;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == CNT_W'(1)) begin
                        if (index == LAST_IDX) begin
                            state  <= ST_FIN;
                            finish <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= ST_GEN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    if (start) begin
                        state <= ST_GEN;
                        index <= '0;
                        drawn <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lottery_draw.sv
// tb/tb_lottery_draw.sv - self-checking bench for lottery_draw (honours LOTTERY_DRAW_UNIQUE_EN)
module tb_lottery_draw;

    localparam int          D      = 5;
    localparam int          G      = 4;
    localparam logic [15:0] SEED_A = 16'hACE1;
    // C006 -> 800D (13, reject) -> 001B (11, reject) -> 0036 (6, accept)
    localparam logic [15:0] SEED_B = 16'hC006;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, start;
    logic [3:0]     num;
    logic           insert, finish, busy, done;
    logic [4*D-1:0] drawn;

    logic           reset_b, start_b;
    logic [3:0]     num_b;
    logic           insert_b, finish_b, busy_b, done_b;
    logic [4*D-1:0] drawn_b;

    int checks = 0;
    int errors = 0;

    lottery_draw #(.DIGITS(D), .GAP_CYCLES(G), .SEED(SEED_A)) dut (
        .clk(clk), .reset(reset), .start(start), .num(num), .insert(insert),
        .finish(finish), .busy(busy), .done(done), .drawn(drawn)
    );

    lottery_draw #(.DIGITS(D), .GAP_CYCLES(G), .SEED(SEED_B)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .num(num_b), .insert(insert_b),
        .finish(finish_b), .busy(busy_b), .done(done_b), .drawn(drawn_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // reference LFSR tracking the main instance cycle by cycle
    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= reset ? SEED_A : step(m_lfsr);

    logic [3:0] dig [D];
    logic [3:0] got [D];
    int         ins_c [D];
    int         fin_c;

    function automatic bit acceptable(input logic [3:0] v, input int d);
        if (v > 4'd9) return 1'b0;
`ifdef LOTTERY_DRAW_UNIQUE_EN
        for (int k = 0; k < d; k++) if (dig[k] == v) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic run_round(input bit inject, input bit abort, input int tag);
        logic [15:0]    l;
        logic [4*D-1:0] exp_drawn;
        int             c, nxt, guard, seen, n_ins, dups;
        bit             exp_i;
        l = m_lfsr;
        c = 0;
        exp_drawn = '0;
        for (int d = 0; d < D; d++) begin
            nxt = (d == 0) ? 1 : ins_c[d-1] + G;
            while (c < nxt) begin l = step(l); c++; end
            guard = 0;
            while (!acceptable(l[3:0], d) && guard < 1000) begin l = step(l); c++; guard++; end
            dig[d]   = l[3:0];
            ins_c[d] = c + 1;
            exp_drawn[4*d +: 4] = l[3:0];
        end
        fin_c = ins_c[D-1] + G;

        start = 1'b1;
        seen  = 0;
        n_ins = 0;
        for (int cyc = 1; cyc <= fin_c + 1; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 1) begin
                check($sformatf("r%0d_gen_busy", tag), busy, 1);
                check($sformatf("r%0d_gen_drawn_clear", tag), drawn, 0);
                check($sformatf("r%0d_gen_done", tag), done, 0);
            end
            exp_i = (seen < D) && (cyc == ins_c[seen]);
            check($sformatf("r%0d_insert_c%0d", tag, cyc), insert, exp_i);
            check($sformatf("r%0d_finish_c%0d", tag, cyc), finish, cyc == fin_c);
            if (insert) begin
                if (n_ins < D) got[n_ins] = num;
                n_ins++;
            end
            if (exp_i) begin
                check($sformatf("r%0d_num%0d", tag, seen), num, dig[seen]);
                seen++;
            end
            if (inject && (cyc == ins_c[0] + 1 || cyc == fin_c)) start = 1'b1;
            if (abort && cyc == ins_c[2] + 2) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_drawn", drawn, 0);
                check("abort_num", num, 0);
                check("abort_insert", insert, 0);
                check("abort_finish", finish, 0);
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("abort_quiet_finish%0d", k), finish, 0);
                end
                return;
            end
        end
        check($sformatf("r%0d_done", tag), done, 1);
        check($sformatf("r%0d_busy_off", tag), busy, 0);
        check($sformatf("r%0d_drawn", tag), drawn, exp_drawn);
        check($sformatf("r%0d_insert_count", tag), n_ins, D);
`ifdef LOTTERY_DRAW_UNIQUE_EN
        dups = 0;
        for (int a = 0; a < D; a++)
            for (int b = a + 1; b < D; b++)
                if (got[a] == got[b]) dups++;
        check($sformatf("r%0d_unique", tag), dups, 0);
`else
        dups = 0;
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic        ins;
        logic [3:0]  n;
        logic        bsy;
        logic        dn;
        logic        fin;
        logic [19:0] drw;
    } vec_t;

    vec_t vt [8];

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 20'h0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 20'h0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 20'h0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 20'h0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 20'h0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 20'h6};
        vt[6] = '{1'b0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 20'h6};
        vt[7] = '{1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 20'h6};

        reset   = 1'b1;
        start   = 1'b0;
        reset_b = 1'b1;
        start_b = 1'b0;

        for (int i = 0; i < 8; i++) begin
            reset_b = vt[i].rst;
            start_b = vt[i].st;
            @(posedge clk); #1;
            check($sformatf("vec%0d_insert", i), insert_b, vt[i].ins);
            check($sformatf("vec%0d_num", i), num_b, vt[i].n);
            check($sformatf("vec%0d_busy", i), busy_b, vt[i].bsy);
            check($sformatf("vec%0d_done", i), done_b, vt[i].dn);
            check($sformatf("vec%0d_finish", i), finish_b, vt[i].fin);
            check($sformatf("vec%0d_drawn", i), drawn_b, vt[i].drw);
        end
        start_b = 1'b0;

        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("idle_num", num, 0);
        check("idle_insert", insert, 0);
        check("idle_finish", finish, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_drawn", drawn, 0);

        run_round(1'b0, 1'b0, 0);
        run_round(1'b1, 1'b0, 1);
        run_round(1'b0, 1'b1, 2);
        run_round(1'b0, 1'b0, 3);
        for (int r = 0; r < 200; r++) run_round(1'b0, 1'b0, 100 + r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
